// File: rtl/image_pkg.sv
// Shared frame-buffer constants and types used by both the write path and the VGA read path.
package image_pkg;

    localparam int unsigned H_RES        = 320;
    localparam int unsigned V_RES        = 240;
    localparam int unsigned FRAME_PIXELS = H_RES * V_RES;
    localparam int unsigned ADDR_W       = 17;

    localparam logic [7:0] SYNC0 = 8'hAA;
    localparam logic [7:0] SYNC1 = 8'h55;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PIX_HI,
        PIX_LO,
        DONE
    } wr_state_t;

    // Linear buffer address shared by the writer and the downscaled read lookup.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
        return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/image_frame_writer.sv
// Receives a sync-prefixed byte stream and writes 12-bit pixels into the frame buffer,
// one write per hi/lo byte pair, with a byte-gap timeout inside a frame.
module image_frame_writer #(
    parameter int unsigned H_RES          = 320,
    parameter int unsigned V_RES          = 240,
    parameter int unsigned ADDR_W         = 17,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              abort,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err
);
    import image_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);
    localparam int unsigned       GAP_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    wr_state_t         state_q;
    logic [ADDR_W-1:0] pix_q;
    logic [GAP_W-1:0]  gap_q;
    logic [3:0]        red_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    rgb12_t            wr_data_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              timeout_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pix_q         <= '0;
            gap_q         <= '0;
            red_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            wr_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                pix_q   <= '0;
                gap_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rx_valid && rx_data == SYNC0) state_q <= SYNC;
                    end
                    SYNC: begin
                        if (rx_valid) begin
                            if (rx_data == SYNC1) begin
                                state_q <= PIX_HI;
                                pix_q   <= '0;
                                gap_q   <= '0;
                                busy_q  <= 1'b1;
                            end else if (rx_data != SYNC0) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    PIX_HI, PIX_LO: begin
                        // An arriving byte always beats an expiring gap counter.
                        if (rx_valid) begin
                            gap_q <= '0;
                            if (state_q == PIX_HI) begin
                                red_q   <= rx_data[3:0];
                                state_q <= PIX_LO;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= pix_q;
                                wr_data_q <= {red_q, rx_data};
                                if (pix_q == LAST_PIX) begin
                                    state_q <= DONE;
                                    busy_q  <= 1'b0;
                                    pix_q   <= '0;
                                end else begin
                                    state_q <= PIX_HI;
                                    pix_q   <= pix_q + 1'b1;
                                end
                            end
                        end else if (gap_q == GAP_LAST) begin
                            state_q       <= IDLE;
                            busy_q        <= 1'b0;
                            timeout_err_q <= 1'b1;
                            gap_q         <= '0;
                            pix_q         <= '0;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    DONE: begin
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_image_frame_writer.sv
// Scoreboard bench for image_frame_writer on a reduced 8x4 frame with a 16-cycle byte-gap timeout.
module tb_image_frame_writer;

    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned NP = H * V;
    localparam int unsigned AW = 17;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          abort = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;

    int tests = 0;
    int fails = 0;
    int done_exp = 0;
    logic prev_wr = 1'b0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;
    wr_t exp_q[$];

    image_frame_writer #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .abort(abort),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard; frame_done must follow a write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: addr %0d data %03h, none expected", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        fails++;
                        $display("FAIL write: got addr %0d data %03h expected addr %0d data %03h",
                                 wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
            if (frame_done) begin
                tests++;
                if (!prev_wr || done_exp == 0) begin
                    fails++;
                    $display("FAIL frame_done: prev_wr %0b pending %0d, required 1 and >0", prev_wr, done_exp);
                end else begin
                    done_exp--;
                end
            end
            prev_wr = wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo, input int unsigned addr);
        wr_t e;
        e.addr = AW'(addr);
        e.data = {hi[3:0], lo};
        exp_q.push_back(e);
        send(hi);
        send(lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int k;
        logic [11:0] p;

        // Reset values
        #12;
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_wr_addr", 32'(wr_addr), 0);
        chk("reset_wr_data", 32'(wr_data), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        chk("reset_timeout_err", 32'(timeout_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Full back-to-back frame; upper nibble of hi byte carries junk
        done_exp = 1;
        send(8'hAA);
        send(8'h55);
        chk("busy_after_sync", 32'(busy), 1);
        for (int i = 0; i < int'(NP); i++) begin
            p = 12'(i * 12'h123 + 7);
            send_pix({4'(i), p[11:8]}, p[7:0], i);
        end
        idle(3);
        chk("full_frame_writes_left", 32'(exp_q.size()), 0);
        chk("full_frame_done_seen", 32'(done_exp), 0);
        chk("busy_after_frame", 32'(busy), 0);

        // Junk prefix and repeated sync byte, then 0xFF hi byte
        send(8'h12);
        send(8'hAA);
        send(8'hAA);
        send(8'h55);
        send_pix(8'h0F, 8'h3C, 0);
        send_pix(8'hFF, 8'h00, 1);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        idle(2);
        chk("prefix_writes_left", 32'(exp_q.size()), 0);

        // Broken sync: nothing written, never busy
        send(8'hAA);
        send(8'h13);
        chk("syncfail_busy_a", 32'(busy), 0);
        send(8'h55);
        send(8'h01);
        send(8'h02);
        chk("syncfail_busy_b", 32'(busy), 0);
        idle(2);

        // Byte-gap timeout after three pixels
        send(8'hAA);
        send(8'h55);
        send_pix(8'h01, 8'h11, 0);
        send_pix(8'h02, 8'h22, 1);
        send_pix(8'h03, 8'h33, 2);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (timeout_err) begin
                k = i;
                break;
            end
        end
        chk("timeout_latency", 32'(k), TO);
        chk("timeout_busy", 32'(busy), 0);
        idle(1);
        chk("timeout_pulse_width", 32'(timeout_err), 0);
        chk("timeout_writes_left", 32'(exp_q.size()), 0);
        send(8'hAA);
        send(8'h55);
        send_pix(8'h04, 8'h44, 0);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        idle(2);
        chk("after_timeout_restart", 32'(exp_q.size()), 0);

        // Abort mid-frame with a coincident lo byte
        send(8'hAA);
        send(8'h55);
        for (int i = 0; i < 5; i++) send_pix(8'(i), 8'(i + 8'h40), i);
        send(8'h07);
        abort = 1'b1;
        send(8'h77);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        for (int i = 0; i < 6; i++) send(8'h31);
        idle(TO + 4);
        chk("abort_writes_left", 32'(exp_q.size()), 0);
        chk("abort_no_timeout", 32'(timeout_err), 0);

        // Async reset during PIX_LO
        send(8'hAA);
        send(8'h55);
        for (int i = 0; i < 3; i++) send_pix(8'h0A, 8'(i + 8'hB0), i);
        send(8'h0C);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h55);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        idle(3);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_writes_left", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
